// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter, the display fetcher and the CPU bus decoder.
package vram_pkg;

    // Default VRAM geometry: 128K words of 32 bits.
    localparam int VRAM_AW = 17;
    localparam int VRAM_DW = 32;

    // Arbiter access sequence: grant, VRAM sample, read data valid, ack pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    // Current owner of the VRAM port.
    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has fixed priority over the CPU,
// every access takes four cycles, and a sticky flag records late display fetches.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW            = VRAM_AW,
    parameter int DW            = VRAM_DW,
    parameter int DISP_DEADLINE = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              disp_req,
    input  logic [AW-1:0]     disp_addr,
    output logic              disp_ack,
    output logic [DW-1:0]     disp_rdata,
    output logic              disp_late,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DW/8-1:0]   cpu_be,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_ack,
    output logic [DW-1:0]     cpu_rdata,
    output logic              vram_en,
    output logic [DW/8-1:0]   vram_we,
    output logic [AW-1:0]     vram_addr,
    output logic [DW-1:0]     vram_wdata,
    input  logic [DW-1:0]     vram_rdata
);

    localparam int BW = DW / 8;
    // Counter only needs to reach DISP_DEADLINE+1, where it saturates.
    localparam int CW = $clog2(DISP_DEADLINE + 2);
    localparam logic [CW-1:0] LATE_CNT = CW'(DISP_DEADLINE + 1);

    arb_state_t      state_q, state_d;
    arb_owner_t      own_q, own_d;
    logic            wr_q, wr_d;
    logic            en_q, en_d;
    logic [BW-1:0]   we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            dack_q, dack_d;
    logic            cack_q, cack_d;
    logic [DW-1:0]   drd_q, drd_d;
    logic [DW-1:0]   crd_q, crd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            late_q, late_d;

    // Access sequencer: arbitrate in IDLE, then walk ISSUE -> WAIT -> ACK.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr_d    = wr_q;
        en_d    = 1'b0;
        we_d    = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dack_d  = 1'b0;
        cack_d  = 1'b0;
        drd_d   = drd_q;
        crd_d   = crd_q;
        case (state_q)
            ST_IDLE: begin
                if (disp_req || cpu_req) begin
                    own_d   = disp_req ? OWN_DISP : OWN_CPU;
                    wr_d    = !disp_req && cpu_we;
                    en_d    = 1'b1;
                    addr_d  = disp_req ? disp_addr : cpu_addr;
                    we_d    = (!disp_req && cpu_we) ? cpu_be : '0;
                    wdata_d = cpu_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Read data arrives one cycle after the strobe; writes keep the old cpu_rdata.
                if (own_q == OWN_DISP) begin
                    drd_d  = vram_rdata;
                    dack_d = 1'b1;
                end else begin
                    if (!wr_q) crd_d = vram_rdata;
                    cack_d = 1'b1;
                end
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Deadline watchdog: count cycles a display request waits, latch lateness.
    always_comb begin
        cnt_d = '0;
        if (disp_req && !dack_q) begin
            cnt_d = (cnt_q == LATE_CNT) ? cnt_q : cnt_q + CW'(1);
        end
        late_d = late_q | (cnt_d == LATE_CNT);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            own_q   <= OWN_DISP;
            wr_q    <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dack_q  <= 1'b0;
            cack_q  <= 1'b0;
            drd_q   <= '0;
            crd_q   <= '0;
            cnt_q   <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dack_q  <= dack_d;
            cack_q  <= cack_d;
            drd_q   <= drd_d;
            crd_q   <= crd_d;
            cnt_q   <= cnt_d;
            late_q  <= late_d;
        end
    end

    assign vram_en    = en_q;
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign disp_ack   = dack_q;
    assign disp_rdata = drd_q;
    assign disp_late  = late_q;
    assign cpu_ack    = cack_q;
    assign cpu_rdata  = crd_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a primary instance with the default deadline
// and a second instance with a deadline of 2 for the lateness flag.
module tb_vram_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Primary instance signals
    logic          disp_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] disp_addr = '0, cpu_addr = '0;
    logic [BW-1:0] cpu_be = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          disp_ack, cpu_ack, disp_late, vram_en;
    logic [DW-1:0] disp_rdata, cpu_rdata, vram_wdata, vram_rdata;
    logic [BW-1:0] vram_we;
    logic [AW-1:0] vram_addr;

    // Second instance signals (DISP_DEADLINE = 2)
    logic          disp_req2 = 1'b0, cpu_req2 = 1'b0;
    logic          disp_ack2, cpu_ack2, late2, vram_en2;
    logic [DW-1:0] disp_rdata2, cpu_rdata2, vram_wdata2;
    logic [DW-1:0] vram_rdata2 = '0;
    logic [BW-1:0] vram_we2;
    logic [AW-1:0] vram_addr2;

    vram_arbiter #(.AW(AW), .DW(DW), .DISP_DEADLINE(6)) dut (
        .CLK(CLK), .RST(RST),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .disp_late(disp_late),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    vram_arbiter #(.AW(AW), .DW(DW), .DISP_DEADLINE(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .disp_req(disp_req2), .disp_addr(17'h00100), .disp_ack(disp_ack2),
        .disp_rdata(disp_rdata2), .disp_late(late2),
        .cpu_req(cpu_req2), .cpu_we(1'b0), .cpu_be(4'b0000), .cpu_addr(17'h00000),
        .cpu_wdata(32'h0), .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
        .vram_en(vram_en2), .vram_we(vram_we2), .vram_addr(vram_addr2),
        .vram_wdata(vram_wdata2), .vram_rdata(vram_rdata2)
    );

    // VRAM model: 256 words indexed by the low address byte, 1-cycle read latency.
    logic [DW-1:0] mem [0:255];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_idx = '0;
    logic [DW-1:0] pl_val = '0;
    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (vram_en) begin
            vram_rdata <= mem[vram_addr[7:0]];
            for (int b = 0; b < BW; b++)
                if (vram_we[b]) mem[vram_addr[7:0]][8*b +: 8] <= vram_wdata[8*b +: 8];
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit            is_cpu;
        int            edge_no;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    task automatic push(input bit is_cpu, input int edge_no, input logic [DW-1:0] data);
        exp_t e;
        e.is_cpu  = is_cpu;
        e.edge_no = edge_no;
        e.data    = data;
        q.push_back(e);
    endtask

    // Monitor: every ack must match the next expected completion in owner, edge and data.
    initial forever begin
        @(negedge CLK);
        if (disp_ack || cpu_ack) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {disp_ack, cpu_ack}, 2'b00);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_owner", {disp_ack, cpu_ack}, e.is_cpu ? 2'b01 : 2'b10);
                chk("ack_edge", cyc + 1, e.edge_no);
                chk(e.is_cpu ? "cpu_rdata" : "disp_rdata",
                    e.is_cpu ? cpu_rdata : disp_rdata, e.data);
            end
        end
    end

    task automatic wait_ack(input bit is_cpu);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = is_cpu ? cpu_ack : disp_ack;
        end
        if (!seen) chk(is_cpu ? "cpu_ack_timeout" : "disp_ack_timeout", 0, 1);
        if (is_cpu) cpu_req = 1'b0;
        else        disp_req = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [DW-1:0] v);
        @(negedge CLK);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = v;
        @(negedge CLK);
        pl_en  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, m;
        bit seen;

        // Reset state and memory preload
        preload(8'h10, 32'h11223344);
        preload(8'hFF, 32'h12345678);
        preload(8'h20, 32'hCAFEF00D);
        preload(8'h30, 32'h0BADC0DE);
        chk("rst_vram_en", vram_en, 0);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_outputs", {disp_ack, cpu_ack, disp_late, disp_rdata, cpu_rdata}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Single CPU write with byte enables
        @(negedge CLK);
        k = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0101;
        cpu_addr = 17'h00010; cpu_wdata = 32'hDEADBEEF;
        push(1'b1, k + 4, 32'h0);
        chk("wr_en_before_grant", vram_en, 0);
        @(negedge CLK);
        chk("wr_vram_en", vram_en, 1);
        chk("wr_vram_we", vram_we, 4'b0101);
        chk("wr_vram_addr", vram_addr, 17'h00010);
        chk("wr_vram_wdata", vram_wdata, 32'hDEADBEEF);
        @(negedge CLK);
        chk("wr_en_cleared", {vram_en, vram_we}, 0);
        wait_ack(1'b1);
        cpu_we = 1'b0;

        // Display read of top address; CPU read-back of merged word queued behind it
        @(negedge CLK);
        k = cyc;
        disp_req = 1'b1; disp_addr = 17'h1FFFF;
        push(1'b0, k + 4, 32'h12345678);
        fork
            wait_ack(1'b0);
            begin
                @(negedge CLK);
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
                push(1'b1, k + 8, 32'h11AD33EF);
                wait_ack(1'b1);
            end
            begin
                repeat (4) @(negedge CLK);
                chk("no_early_grant", vram_en, 0);
                @(negedge CLK);
                chk("grant_at_t4", vram_en, 1);
            end
        join

        // Simultaneous requests: display first, CPU four cycles later
        @(negedge CLK);
        k = cyc;
        disp_req = 1'b1; disp_addr = 17'h00020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00030;
        push(1'b0, k + 4, 32'hCAFEF00D);
        push(1'b1, k + 8, 32'h0BADC0DE);
        fork
            wait_ack(1'b0);
            wait_ack(1'b1);
        join
        chk("late_after_simul", disp_late, 0);

        // Display request arriving while a CPU write sits in ISSUE
        @(negedge CLK);
        k = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b1111;
        cpu_addr = 17'h00040; cpu_wdata = 32'hA5A5A5A5;
        push(1'b1, k + 4, 32'h0BADC0DE);
        fork
            wait_ack(1'b1);
            begin
                @(negedge CLK);
                disp_req = 1'b1; disp_addr = 17'h00040;
                push(1'b0, k + 8, 32'hA5A5A5A5);
                wait_ack(1'b0);
            end
        join
        cpu_we = 1'b0;
        chk("late_after_blocked", disp_late, 0);

        // Deadline of 2 on the second instance with the CPU holding its request
        @(negedge CLK);
        cpu_req2 = 1'b1;
        @(negedge CLK);
        disp_req2 = 1'b1;
        @(negedge CLK);
        chk("late2_early", late2, 0);
        repeat (3) @(negedge CLK);
        chk("late2_set", late2, 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = disp_ack2;
        end
        if (!seen) chk("disp_ack2_timeout", 0, 1);
        disp_req2 = 1'b0;
        repeat (10) @(negedge CLK);
        chk("late2_sticky", late2, 1);
        cpu_req2 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("late1_still_clear", disp_late, 0);

        // Reset during WAIT of a CPU read, request held across reset
        @(negedge CLK);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00020;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_mid_vram", {vram_en, vram_we, vram_addr, vram_wdata}, 0);
        chk("rst_mid_acks", {disp_ack, cpu_ack}, 0);
        chk("rst_mid_rdata", {disp_rdata, cpu_rdata}, 0);
        chk("rst_mid_late2", late2, 0);
        repeat (2) @(negedge CLK);
        chk("rst_no_ack", cpu_ack, 0);
        RST = 1'b0;
        m = cyc;
        push(1'b1, m + 4, 32'hCAFEF00D);
        wait_ack(1'b1);

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares the single-port synchronous VRAM between two requesters:
  - the display scan-out fetcher, which runs from the VGA sync counters;
  - the CPU memory-mapped VRAM port.
- Display fetches have fixed priority, and the block flags any display fetch that misses its deadline.
- It sits between the sync/pixel path, the CPU bus and the VRAM macro.

## Interface
Parameters:
- AW, 17, VRAM word-address width
- DW, 32, VRAM data width (byte enables = DW/8)
- DISP_DEADLINE, 6, max CLK cycles disp_req may stay high before disp_ack without flagging late

Ports:
- CLK  in  1  system clock; all logic on posedge CLK
- RST  in  1  asynchronous, active-high reset
- disp_req  in  1  display fetch request; level, held until disp_ack
- disp_addr  in  AW  display word address; stable while disp_req high
- disp_ack  out  1  one-cycle pulse; disp_rdata valid in the same cycle
- disp_rdata  out  DW  display read data
- disp_late  out  1  sticky flag: a display fetch exceeded DISP_DEADLINE
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  DW/8  write byte enables
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse; completes read or write
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- vram_en  out  1  VRAM access strobe
- vram_we  out  DW/8  VRAM byte write enables
- vram_addr  out  AW  VRAM address
- vram_wdata  out  DW  VRAM write data
- vram_rdata  in  DW  VRAM read data; 1-cycle synchronous latency after vram_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK; owner register own ∈ {DISP, CPU}.
- IDLE: if disp_req, grant DISP; else if cpu_req, grant CPU; else stay.
  - On grant, register the VRAM outputs and go to ISSUE:
    - vram_en = 1
    - vram_addr = owner address
    - vram_we = cpu_be if CPU write, else 0
    - vram_wdata = cpu_wdata
- ISSUE: VRAM samples the access. Clear vram_en and vram_we, go to WAIT.
- WAIT: vram_rdata is valid. Capture it into disp_rdata or cpu_rdata (reads only), assert the owner's ack, go to ACK.
- ACK: the ack is high this cycle. Drop ack, go to IDLE.
  - The requester deasserts req at the edge ending ACK, so IDLE never re-grants a completed request.
- A CPU write still passes through WAIT/ACK; cpu_rdata holds its previous value.
- Arbitration is non-preemptive: a request arriving mid-access waits for IDLE.
- Deadline counter:
  - counts CLK cycles while disp_req is high and disp_ack is low; saturates at DISP_DEADLINE+1;
  - clears when disp_ack pulses or disp_req is low;
  - when the count reaches DISP_DEADLINE+1, disp_late is set; only RST clears it.
- Address and width rules: addresses pass straight through with no arithmetic; all widths come from the parameters.

## Timing
- Reset values: state IDLE; vram_en, vram_we, disp_ack, cpu_ack and disp_late are 0; vram_addr, vram_wdata, disp_rdata and cpu_rdata are 0; deadline counter 0.
- Latency: request seen high in IDLE at edge t → vram_en high t+1 → ack high t+3 → IDLE at t+4.
- Throughput: one access per 4 cycles.
- Simultaneous disp_req and cpu_req in IDLE: DISP is granted; CPU is granted at the following IDLE.
- Worst-case CPU wait: one display access (4 cycles) plus its own 4, provided display requests are ≥ 8 cycles apart (the scan-out rate at PCK = CLK/2).
- Reset mid-access: all outputs return to reset values immediately; no ack is issued for the aborted access. A request still held is re-arbitrated from IDLE after RST falls.
- Request dropped before ack (protocol violation): the access completes and the ack still pulses.

## Structure
- Shared package vram_pkg:
  - FSM state encoding (2-bit);
  - owner encoding;
  - default AW and DW constants, also used by the display fetcher and CPU bus decoder.
- Single module, no sub-module; the deadline counter stays inline.

## Test plan
- Single CPU write: cpu_be=4'b0101, addr 0x00010, wdata 0xDEADBEEF → vram_en and vram_we=0101 exactly at t+1, cpu_ack at t+3. A later read of 0x00010 returns the byte-merged word.
- Single display read of 0x1FFFF (preloaded 0x12345678) → disp_ack at t+3 with disp_rdata=0x12345678; the next grant is not earlier than t+4.
- Simultaneous disp_req and cpu_req at the same edge → display served first (disp_ack at t+3), cpu_ack at t+7; disp_late stays 0.
- Display request issued while a CPU access sits in ISSUE → disp_ack 6 cycles after disp_req rises; disp_late stays 0 with DISP_DEADLINE=6.
- Set DISP_DEADLINE=2 and hold cpu_req continuously. Raise disp_req one cycle after a CPU grant → disp_late sets and stays set through later accesses until RST.
- Assert RST in WAIT of a CPU read → no cpu_ack, all outputs 0. With cpu_req still high after RST falls → fresh access, cpu_ack 3 cycles after the first IDLE edge.
